deconcatenate_sink: RTL

Receive-side counterpart of the 4-lane concatenated sample stream: accepts the four valid/data lanes produced at 200 MHz, reassembles each 10-channel frame, and presents it as one flat registered bus with a single-cycle frame strobe. A built-in ramp checker confirms that every channel advances by STRIDE between frames. The block sits at the CGRA output / test-harness end of the datapath, where it is used for loopback verification and result capture.

---
 rtl/deconcatenate_sink_pkg.sv | 18 +
 rtl/deconcatenate_sink_ramp_checker.sv | 49 ++++
 rtl/deconcatenate_sink.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/deconcatenate_sink_pkg.sv
// Shared constants and types for the 4-lane frame reassembly sink.
// The two legal lane patterns define which lanes may carry data in each beat.
package deconcatenate_sink_pkg;

    localparam int NUM_CHANNELS    = 10;
    localparam int NUM_LANES       = 4;
    localparam int BEATS_PER_FRAME = 3;

    localparam logic [NUM_LANES-1:0] PATTERN_FULL = 4'b1111;
    localparam logic [NUM_LANES-1:0] PATTERN_TAIL = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT0,
        ST_GOT1
    } state_t;

endpackage

// File: rtl/deconcatenate_sink_ramp_checker.sv
// Ramp checker: remembers the last completed frame and flags any channel that
// did not advance by exactly STRIDE (mod 2^DATA_WIDTH) on the next frame.
module ramp_checker
    import deconcatenate_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRIDE     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data,
    input  logic                               frame_strobe,
    output logic                               seq_error
);

    localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);

    logic [NUM_CHANNELS*DATA_WIDTH-1:0] ref_data;
    logic                               ref_valid;
    logic                               mismatch;
    logic [DATA_WIDTH-1:0]              expected_word;

    always_comb begin
        mismatch      = 1'b0;
        expected_word = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            expected_word = ref_data[k*DATA_WIDTH +: DATA_WIDTH] + STRIDE_W;
            if (frame_data[k*DATA_WIDTH +: DATA_WIDTH] != expected_word) begin
                mismatch = 1'b1;
            end
        end
    end

    // The first frame after reset has nothing to compare against; it only seeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_data  <= '0;
            ref_valid <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            seq_error <= frame_strobe && ref_valid && mismatch;
            if (frame_strobe) begin
                ref_data  <= frame_data;
                ref_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/deconcatenate_sink.sv
// Reassembles 10-channel frames from three beats on four valid/data lanes and
// presents each completed frame as one registered bus with status strobes.
module deconcatenate_sink
    import deconcatenate_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRIDE     = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_channel1_data1_valid,
    input  logic [DATA_WIDTH-1:0]              in_channel1_data1,
    input  logic                               in_channel1_data2_valid,
    input  logic [DATA_WIDTH-1:0]              in_channel1_data2,
    input  logic                               in_channel2_data1_valid,
    input  logic [DATA_WIDTH-1:0]              in_channel2_data1,
    input  logic                               in_channel2_data2_valid,
    input  logic [DATA_WIDTH-1:0]              in_channel2_data2,
    output logic                               out_frame_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_frame_data,
    output logic                               out_frame_error,
    output logic                               out_seq_error,
    output logic [15:0]                        out_frame_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int BUF_W = 2 * NUM_LANES * DATA_WIDTH;

    state_t                             state;
    state_t                             state_next;
    logic [NUM_LANES-1:0]               pattern;
    logic                               beat;
    logic [DATA_WIDTH-1:0]              lane_data [NUM_LANES];
    logic [BUF_W-1:0]                   part_buf;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_next;
    logic [CNT_W-1:0]                   idle_cnt;
    logic                               load_beat0;
    logic                               load_beat1;
    logic                               frame_done;
    logic                               frame_err;
    logic                               cnt_clear;
    logic                               cnt_inc;
    logic                               timed_out;

    assign pattern      = {in_channel2_data2_valid, in_channel2_data1_valid,
                           in_channel1_data2_valid, in_channel1_data1_valid};
    assign beat         = |pattern;
    assign lane_data[0] = in_channel1_data1;
    assign lane_data[1] = in_channel1_data2;
    assign lane_data[2] = in_channel2_data1;
    assign lane_data[3] = in_channel2_data2;
    assign frame_next   = {lane_data[1], lane_data[0], part_buf};
    assign timed_out    = (idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full-pattern beat while waiting for the tail aborts the frame but is
    // kept as the first beat of a new one.
    always_comb begin
        state_next = state;
        load_beat0 = 1'b0;
        load_beat1 = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (beat) begin
                    if (pattern == PATTERN_FULL) begin
                        load_beat0 = 1'b1;
                        state_next = ST_GOT0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_GOT0: begin
                if (beat) begin
                    cnt_clear = 1'b1;
                    if (pattern == PATTERN_FULL) begin
                        load_beat1 = 1'b1;
                        state_next = ST_GOT1;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (timed_out) begin
                    cnt_clear  = 1'b1;
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_GOT1: begin
                if (beat) begin
                    cnt_clear = 1'b1;
                    if (pattern == PATTERN_TAIL) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end else if (pattern == PATTERN_FULL) begin
                        frame_err  = 1'b1;
                        load_beat0 = 1'b1;
                        state_next = ST_GOT0;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (timed_out) begin
                    cnt_clear  = 1'b1;
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt        <= '0;
            part_buf        <= '0;
            out_frame_valid <= 1'b0;
            out_frame_error <= 1'b0;
            out_frame_data  <= '0;
            out_frame_count <= '0;
        end else begin
            out_frame_valid <= frame_done;
            out_frame_error <= frame_err;
            if (cnt_clear) begin
                idle_cnt <= '0;
            end else if (cnt_inc) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
            if (load_beat0) begin
                part_buf[0 +: NUM_LANES*DATA_WIDTH] <=
                    {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};
            end
            if (load_beat1) begin
                part_buf[NUM_LANES*DATA_WIDTH +: NUM_LANES*DATA_WIDTH] <=
                    {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};
            end
            if (frame_done) begin
                out_frame_data  <= frame_next;
                out_frame_count <= out_frame_count + 16'd1;
            end
        end
    end

    ramp_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRIDE     (STRIDE)
    ) u_ramp_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_data   (frame_next),
        .frame_strobe (frame_done),
        .seq_error    (out_seq_error)
    );

endmodule
